// File: rtl/ppu_reg_responder_pkg.sv
// Shared definitions for the PPU register responder: register indices, control/status bit positions, palette base.
package ppu_reg_responder_pkg;

    typedef enum logic [2:0] {
        REG_PPUCTRL   = 3'd0,
        REG_PPUMASK   = 3'd1,
        REG_PPUSTATUS = 3'd2,
        REG_OAMADDR   = 3'd3,
        REG_OAMDATA   = 3'd4,
        REG_PPUSCROLL = 3'd5,
        REG_PPUADDR   = 3'd6,
        REG_PPUDATA   = 3'd7
    } reg_idx_e;

    localparam int CTRL_INC32    = 2;
    localparam int CTRL_NMI_EN   = 7;
    localparam int STATUS_OVF    = 5;
    localparam int STATUS_SPR0   = 6;
    localparam int STATUS_VBLANK = 7;

    localparam logic [13:0] PALETTE_BASE = 14'h3F00;

    function automatic logic [7:0] status_byte(input logic vblank, input logic spr0,
                                               input logic ovf, input logic [4:0] low5);
        logic [7:0] s;
        s                = {3'b000, low5};
        s[STATUS_VBLANK] = vblank;
        s[STATUS_SPR0]   = spr0;
        s[STATUS_OVF]    = ovf;
        return s;
    endfunction

endpackage

// File: rtl/ppu_reg_responder_if.sv
// CPU->PPU register bus: one access per cs rising edge, data_out registered on the PPU side.
interface ppu_reg_responder_if;
    logic       cs;
    logic       rw;
    logic [2:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (output cs, rw, address, data_in, input data_out);
    modport slave  (input cs, rw, address, data_in, output data_out);
endinterface

// File: rtl/ppu_reg_responder_loopy_regs.sv
// Loopy scroll state (t, v, fine_x and the shared $2005/$2006 toggle w), updated on single-cycle strobes.
// v increments by 1 or 32 and wraps naturally at 15 bits.
module ppu_reg_responder_loopy_regs (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_wr,
    input  logic        scroll_wr,
    input  logic        addr_wr,
    input  logic        w_clr,
    input  logic        v_inc,
    input  logic        inc32,
    input  logic [7:0]  d,
    output logic [14:0] v,
    output logic [14:0] t,
    output logic [2:0]  fine_x
);

    logic w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v      <= '0;
            t      <= '0;
            fine_x <= '0;
            w      <= 1'b0;
        end else begin
            if (ctrl_wr)
                t[11:10] <= d[1:0];
            if (scroll_wr) begin
                if (!w) begin
                    t[4:0] <= d[7:3];
                    fine_x <= d[2:0];
                end else begin
                    t[9:5]   <= d[7:3];
                    t[14:12] <= d[2:0];
                end
                w <= ~w;
            end
            if (addr_wr) begin
                if (!w) begin
                    t[13:8] <= d[5:0];
                    t[14]   <= 1'b0;
                end else begin
                    t[7:0] <= d;
                    // v takes the new low byte directly, not the stale t[7:0]
                    v      <= {t[14:8], d};
                end
                w <= ~w;
            end
            if (w_clr)
                w <= 1'b0;
            if (v_inc)
                v <= v + (inc32 ? 15'd32 : 15'd1);
        end
    end

endmodule

// File: rtl/ppu_reg_responder.sv
// PPU-side responder for $2000-$2007: control/mask/status/OAMADDR, loopy scroll, $2007 read buffer, VRAM/OAM strobes, nmi.
// Open-bus latch is built only when PPU_OPEN_BUS_EN is defined; otherwise unused read bits return 0.
module ppu_reg_responder
    import ppu_reg_responder_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    ppu_reg_responder_if.slave bus,
    input  logic               vblank_set,
    input  logic               frame_clr,
    input  logic               spr0_set,
    input  logic               ovf_set,
    output logic [7:0]         ctrl,
    output logic [7:0]         mask,
    output logic [14:0]        v_addr,
    output logic [14:0]        t_addr,
    output logic [2:0]         fine_x,
    output logic [13:0]        vram_addr,
    output logic               vram_we,
    output logic               vram_re,
    output logic [7:0]         vram_wr_data,
    input  logic [7:0]         vram_rd_data,
    output logic [7:0]         oam_addr,
    output logic               oam_we,
    input  logic [7:0]         oam_rd_data,
    output logic               nmi
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_RD_WAIT = 1'b1;
    localparam logic [1:0] LAT_LAST   = 2'(RD_LAT);

    logic [0:0] state;
    logic [1:0] lat_cnt;
    logic       cs_q;
    logic       vblank, spr0, ovf;
    logic [7:0] rd_buf;
    logic [7:0] low8;
    reg_idx_e   idx;

    logic access, wr, rd;
    logic status_rd, data_rd_issue, data_wr, oam_data_wr;
    logic rd_done;
    logic       dout_ld;
    logic [7:0] dout_nxt;

    // Edges arriving while a $2007 read is in flight are dropped
    assign access        = bus.cs & ~cs_q & (state == ST_IDLE);
    assign idx           = reg_idx_e'(bus.address);
    assign wr            = access & ~bus.rw;
    assign rd            = access & bus.rw;
    assign status_rd     = rd & (idx == REG_PPUSTATUS);
    assign data_rd_issue = rd & (idx == REG_PPUDATA);
    assign data_wr       = wr & (idx == REG_PPUDATA);
    assign oam_data_wr   = wr & (idx == REG_OAMDATA);
    assign rd_done       = (state == ST_RD_WAIT) && (lat_cnt == LAT_LAST);

`ifdef PPU_OPEN_BUS_EN
    logic [7:0] io_latch;
    assign low8 = io_latch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            io_latch <= 8'h00;
        else if (wr)
            io_latch <= bus.data_in;
        else if (dout_ld)
            io_latch <= dout_nxt;
    end
`else
    assign low8 = 8'h00;
`endif

    always_comb begin
        dout_ld  = 1'b0;
        dout_nxt = bus.data_out;
        if (rd_done) begin
            dout_ld  = 1'b1;
            dout_nxt = (vram_addr >= PALETTE_BASE) ? vram_rd_data : rd_buf;
        end else if (rd) begin
            dout_ld = 1'b1;
            case (idx)
                REG_PPUSTATUS: dout_nxt = status_byte(vblank, spr0, ovf, low8[4:0]);
                REG_OAMDATA:   dout_nxt = oam_rd_data;
                REG_PPUDATA:   dout_ld  = 1'b0;
                default:       dout_nxt = low8;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q         <= 1'b0;
            state        <= ST_IDLE;
            lat_cnt      <= '0;
            rd_buf       <= 8'h00;
            bus.data_out <= 8'h00;
        end else begin
            cs_q <= bus.cs;
            if (dout_ld)
                bus.data_out <= dout_nxt;
            case (state)
                ST_IDLE: begin
                    if (data_rd_issue) begin
                        state   <= ST_RD_WAIT;
                        lat_cnt <= '0;
                    end
                end
                default: begin
                    if (rd_done) begin
                        state  <= ST_IDLE;
                        rd_buf <= vram_rd_data;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= 8'h00;
            mask     <= 8'h00;
            oam_addr <= 8'h00;
        end else begin
            if (wr && idx == REG_PPUCTRL)
                ctrl <= bus.data_in;
            if (wr && idx == REG_PPUMASK)
                mask <= bus.data_in;
            // The increment waits for the strobe cycle so oam_we pairs with the original address
            if (wr && idx == REG_OAMADDR)
                oam_addr <= bus.data_in;
            else if (oam_we)
                oam_addr <= oam_addr + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank <= 1'b0;
            spr0   <= 1'b0;
            ovf    <= 1'b0;
            nmi    <= 1'b0;
        end else begin
            // A status read racing vblank_set wins, suppressing this frame's nmi
            if (frame_clr || status_rd)
                vblank <= 1'b0;
            else if (vblank_set)
                vblank <= 1'b1;
            if (frame_clr) begin
                spr0 <= 1'b0;
                ovf  <= 1'b0;
            end else begin
                if (spr0_set)
                    spr0 <= 1'b1;
                if (ovf_set)
                    ovf <= 1'b1;
            end
            nmi <= ctrl[CTRL_NMI_EN] & vblank;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vram_we      <= 1'b0;
            vram_re      <= 1'b0;
            oam_we       <= 1'b0;
            vram_addr    <= '0;
            vram_wr_data <= 8'h00;
        end else begin
            vram_we <= data_wr;
            vram_re <= data_rd_issue;
            oam_we  <= oam_data_wr;
            if (data_wr || data_rd_issue)
                vram_addr <= v_addr[13:0];
            if (data_wr || oam_data_wr)
                vram_wr_data <= bus.data_in;
        end
    end

    ppu_reg_responder_loopy_regs u_loopy (
        .clk       (clk),
        .reset     (reset),
        .ctrl_wr   (wr && idx == REG_PPUCTRL),
        .scroll_wr (wr && idx == REG_PPUSCROLL),
        .addr_wr   (wr && idx == REG_PPUADDR),
        .w_clr     (status_rd),
        .v_inc     (data_wr || data_rd_issue),
        .inc32     (ctrl[CTRL_INC32]),
        .d         (bus.data_in),
        .v         (v_addr),
        .t         (t_addr),
        .fine_x    (fine_x)
    );

endmodule

// File: tb/tb_ppu_reg_responder.sv
// Bench for ppu_reg_responder: register-access vector table with a read-data scoreboard, plus nmi/status/OAM/reset sequences.
module tb_ppu_reg_responder;

    logic        clk;
    logic        reset;
    logic        vblank_set, frame_clr, spr0_set, ovf_set;
    logic [7:0]  ctrl, mask;
    logic [14:0] v_addr, t_addr;
    logic [2:0]  fine_x;
    logic [13:0] vram_addr;
    logic        vram_we, vram_re;
    logic [7:0]  vram_wr_data, vram_rd_data;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_rd_data;
    logic        nmi;

    ppu_reg_responder_if bus ();

    ppu_reg_responder dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .vblank_set   (vblank_set),
        .frame_clr    (frame_clr),
        .spr0_set     (spr0_set),
        .ovf_set      (ovf_set),
        .ctrl         (ctrl),
        .mask         (mask),
        .v_addr       (v_addr),
        .t_addr       (t_addr),
        .fine_x       (fine_x),
        .vram_addr    (vram_addr),
        .vram_we      (vram_we),
        .vram_re      (vram_re),
        .vram_wr_data (vram_wr_data),
        .vram_rd_data (vram_rd_data),
        .oam_addr     (oam_addr),
        .oam_we       (oam_we),
        .oam_rd_data  (oam_rd_data),
        .nmi          (nmi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: VRAM with one-cycle read latency, OAM with combinational read
    logic [7:0] vram [0:16383];
    logic [7:0] oam  [0:255];
    logic [7:0] oam_we_addr;

    always @(posedge clk) begin
        if (vram_we) vram[vram_addr] <= vram_wr_data;
        if (vram_re) vram_rd_data <= vram[vram_addr];
        if (oam_we) begin
            oam[oam_addr] <= vram_wr_data;
            oam_we_addr   <= oam_addr;
        end
    end
    assign oam_rd_data = oam[oam_addr];

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] exp_q [$];
    logic [7:0] ob;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [7:0] low8_model();
`ifdef PPU_OPEN_BUS_EN
        return ob;
`else
        return 8'h00;
`endif
    endfunction

    function automatic logic [7:0] st_exp(input logic [2:0] hi);
        logic [7:0] l;
        l = low8_model();
        return {hi, l[4:0]};
    endfunction

    // One CPU access: cs held for three clocks, data_out sampled at the end of the hold
    task automatic acc(input string nm, input logic r, input logic [2:0] a,
                       input logic [7:0] d, input logic [7:0] exp, input logic vb);
        logic [7:0] e;
        @(negedge clk);
        bus.cs = 1'b1; bus.rw = r; bus.address = a; bus.data_in = d; vblank_set = vb;
        if (r) begin
            exp_q.push_back(exp);
            ob = exp;
        end else begin
            ob = d;
        end
        @(negedge clk);
        vblank_set = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (r) begin
            e = exp_q.pop_front();
            chk({nm, " data_out"}, bus.data_out, e);
        end
        bus.cs = 1'b0;
    endtask

    typedef struct {
        logic        rw;
        logic [2:0]  addr;
        logic [7:0]  d;
        logic [1:0]  kind;   // 0 exact data, 1 status (hi bits given), 2 unreadable register
        logic [7:0]  exp_d;
        logic [14:0] exp_v;
        logic [14:0] exp_t;
        logic [2:0]  exp_fx;
    } vec_t;

    vec_t tv [21];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] e;
        reset = 1'b1;
        bus.cs = 1'b0; bus.rw = 1'b0; bus.address = 3'd0; bus.data_in = 8'h00;
        vblank_set = 1'b0; frame_clr = 1'b0; spr0_set = 1'b0; ovf_set = 1'b0;
        ob = 8'h00;
        vram[14'h2000] <= 8'h11;
        vram[14'h2001] <= 8'h22;
        vram[14'h3F00] <= 8'h0F;
        oam[0]         <= 8'h5C;

        tv[0]  = '{1'b0, 3'd6, 8'h21, 2'd0, 8'h00, 15'h0000, 15'h2100, 3'd0};
        tv[1]  = '{1'b0, 3'd6, 8'h08, 2'd0, 8'h00, 15'h2108, 15'h2108, 3'd0};
        tv[2]  = '{1'b0, 3'd7, 8'hAB, 2'd0, 8'h00, 15'h2109, 15'h2108, 3'd0};
        tv[3]  = '{1'b0, 3'd0, 8'h04, 2'd0, 8'h00, 15'h2109, 15'h2108, 3'd0};
        tv[4]  = '{1'b0, 3'd7, 8'hCD, 2'd0, 8'h00, 15'h2129, 15'h2108, 3'd0};
        tv[5]  = '{1'b0, 3'd0, 8'h00, 2'd0, 8'h00, 15'h2129, 15'h2108, 3'd0};
        tv[6]  = '{1'b0, 3'd6, 8'h20, 2'd0, 8'h00, 15'h2129, 15'h2008, 3'd0};
        tv[7]  = '{1'b0, 3'd6, 8'h00, 2'd0, 8'h00, 15'h2000, 15'h2000, 3'd0};
        tv[8]  = '{1'b1, 3'd7, 8'h00, 2'd0, 8'h00, 15'h2001, 15'h2000, 3'd0};
        tv[9]  = '{1'b1, 3'd7, 8'h00, 2'd0, 8'h11, 15'h2002, 15'h2000, 3'd0};
        tv[10] = '{1'b1, 3'd7, 8'h00, 2'd0, 8'h22, 15'h2003, 15'h2000, 3'd0};
        tv[11] = '{1'b0, 3'd6, 8'h3F, 2'd0, 8'h00, 15'h2003, 15'h3F00, 3'd0};
        tv[12] = '{1'b0, 3'd6, 8'h00, 2'd0, 8'h00, 15'h3F00, 15'h3F00, 3'd0};
        tv[13] = '{1'b1, 3'd7, 8'h00, 2'd0, 8'h0F, 15'h3F01, 15'h3F00, 3'd0};
        tv[14] = '{1'b0, 3'd5, 8'h7D, 2'd0, 8'h00, 15'h3F01, 15'h3F0F, 3'd5};
        tv[15] = '{1'b0, 3'd5, 8'h5E, 2'd0, 8'h00, 15'h3F01, 15'h6D6F, 3'd5};
        tv[16] = '{1'b0, 3'd5, 8'h7D, 2'd0, 8'h00, 15'h3F01, 15'h6D6F, 3'd5};
        tv[17] = '{1'b1, 3'd2, 8'h00, 2'd1, 8'h00, 15'h3F01, 15'h6D6F, 3'd5};
        tv[18] = '{1'b0, 3'd5, 8'hFF, 2'd0, 8'h00, 15'h3F01, 15'h6D7F, 3'd7};
        tv[19] = '{1'b0, 3'd5, 8'h00, 2'd0, 8'h00, 15'h3F01, 15'h0C1F, 3'd7};
        tv[20] = '{1'b1, 3'd1, 8'h00, 2'd2, 8'h00, 15'h3F01, 15'h0C1F, 3'd7};

        repeat (3) @(negedge clk);
        chk("rst data_out", bus.data_out, 8'h00);
        chk("rst ctrl", ctrl, 8'h00);
        chk("rst v", v_addr, 15'h0000);
        chk("rst nmi", nmi, 1'b0);
        chk("rst oam_addr", oam_addr, 8'h00);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            case (tv[i].kind)
                2'd1:    e = st_exp(tv[i].exp_d[7:5]);
                2'd2:    e = low8_model();
                default: e = tv[i].exp_d;
            endcase
            acc($sformatf("vec%0d", i), tv[i].rw, tv[i].addr, tv[i].d, e, 1'b0);
            chk($sformatf("vec%0d v_addr", i), v_addr, tv[i].exp_v);
            chk($sformatf("vec%0d t_addr", i), t_addr, tv[i].exp_t);
            chk($sformatf("vec%0d fine_x", i), fine_x, tv[i].exp_fx);
        end
        chk("vram[2108]", vram[14'h2108], 8'hAB);
        chk("vram[2109]", vram[14'h2109], 8'hCD);

        // OAM address/data port
        acc("oamaddr", 1'b0, 3'd3, 8'hFF, 8'h00, 1'b0);
        acc("oamdata", 1'b0, 3'd4, 8'hAA, 8'h00, 1'b0);
        chk("oam_we addr", oam_we_addr, 8'hFF);
        chk("oam[FF]", oam[255], 8'hAA);
        chk("oam_addr wrap", oam_addr, 8'h00);
        acc("oam rd", 1'b1, 3'd4, 8'h00, 8'h5C, 1'b0);
        chk("oam_addr after rd", oam_addr, 8'h00);

        acc("mask wr", 1'b0, 3'd1, 8'h1E, 8'h00, 1'b0);
        chk("mask", mask, 8'h1E);

        // vblank -> nmi, cleared by a status read
        acc("ctrl80", 1'b0, 3'd0, 8'h80, 8'h00, 1'b0);
        @(negedge clk); vblank_set = 1'b1;
        @(negedge clk); vblank_set = 1'b0;
        chk("nmi not yet", nmi, 1'b0);
        @(negedge clk);
        chk("nmi raised", nmi, 1'b1);
        acc("status vbl", 1'b1, 3'd2, 8'h00, st_exp(3'b100), 1'b0);
        chk("nmi cleared", nmi, 1'b0);

        // nmi re-raised by enabling ctrl[7] inside vblank
        acc("ctrl00", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        @(negedge clk); vblank_set = 1'b1;
        @(negedge clk); vblank_set = 1'b0;
        @(negedge clk);
        chk("nmi masked", nmi, 1'b0);
        acc("ctrl80 again", 1'b0, 3'd0, 8'h80, 8'h00, 1'b0);
        chk("nmi reraise", nmi, 1'b1);
        acc("status vbl2", 1'b1, 3'd2, 8'h00, st_exp(3'b100), 1'b0);

        // vblank_set coincident with the status read is swallowed
        acc("status race", 1'b1, 3'd2, 8'h00, st_exp(3'b000), 1'b1);
        chk("race nmi", nmi, 1'b0);
        repeat (3) @(negedge clk);
        chk("race nmi later", nmi, 1'b0);
        acc("status after race", 1'b1, 3'd2, 8'h00, st_exp(3'b000), 1'b0);

        // sprite flags; frame_clr beats a same-cycle set
        @(negedge clk); spr0_set = 1'b1; ovf_set = 1'b1;
        @(negedge clk); spr0_set = 1'b0; ovf_set = 1'b0;
        acc("status spr", 1'b1, 3'd2, 8'h00, st_exp(3'b011), 1'b0);
        acc("status spr kept", 1'b1, 3'd2, 8'h00, st_exp(3'b011), 1'b0);
        @(negedge clk); spr0_set = 1'b1; frame_clr = 1'b1;
        @(negedge clk); spr0_set = 1'b0; frame_clr = 1'b0;
        acc("status frame_clr", 1'b1, 3'd2, 8'h00, st_exp(3'b000), 1'b0);

        acc("ctrl 5A", 1'b0, 3'd0, 8'h5A, 8'h00, 1'b0);
        acc("open bus rd", 1'b1, 3'd0, 8'h00, low8_model(), 1'b0);

        // reset during an in-flight $2007 read
        acc("rr a", 1'b0, 3'd6, 8'h20, 8'h00, 1'b0);
        acc("rr b", 1'b0, 3'd6, 8'h00, 8'h00, 1'b0);
        acc("rr c", 1'b0, 3'd6, 8'h3F, 8'h00, 1'b0);
        @(negedge clk);
        bus.cs = 1'b1; bus.rw = 1'b1; bus.address = 3'd7;
        @(negedge clk);
        chk("rr vram_re", vram_re, 1'b1);
        reset = 1'b1; bus.cs = 1'b0;
        #1;
        chk("rr data_out", bus.data_out, 8'h00);
        chk("rr v", v_addr, 15'h0000);
        chk("rr t", t_addr, 15'h0000);
        chk("rr fine_x", fine_x, 3'd0);
        chk("rr ctrl", ctrl, 8'h00);
        chk("rr mask", mask, 8'h00);
        chk("rr nmi", nmi, 1'b0);
        chk("rr vram_re off", vram_re, 1'b0);
        chk("rr vram_addr", vram_addr, 14'h0000);
        @(negedge clk);
        reset = 1'b0;
        ob = 8'h00;
        acc("post a", 1'b0, 3'd6, 8'h20, 8'h00, 1'b0);
        acc("post b", 1'b0, 3'd6, 8'h01, 8'h00, 1'b0);
        chk("post w cleared v", v_addr, 15'h2001);
        acc("post rd1", 1'b1, 3'd7, 8'h00, 8'h00, 1'b0);
        acc("post rd2", 1'b1, 3'd7, 8'h00, 8'h22, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
